// File: rtl/mvau_inp_buf_ctrl_pkg.sv
// Shared MVAU definitions: controller state encoding and fold/address sizing helpers
// used by the input buffer controller, the input buffer and the weight memory.
package mvau_inp_buf_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } mvau_state_e;

   localparam int unsigned PERF_W = 32;

   function automatic int unsigned calc_fold(input int unsigned len, input int unsigned par);
      return len / par;
   endfunction

   // $clog2 of a depth, floored at one bit so a single-entry fold still has an address port
   function automatic int unsigned addr_bits(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mvau_inp_buf_ctrl.sv
// MVAU input buffer controller: first fold of each vector passes through and is written,
// remaining NF-1 folds are replayed from the buffer. MVAU_INP_CTRL_PERF_EN adds stall/vector counters.
module mvau_inp_buf_ctrl
   import mvau_inp_buf_ctrl_pkg::*;
#(
   parameter int unsigned MatrixW = 20,
   parameter int unsigned SIMD    = 2,
   parameter int unsigned MatrixH = 20,
   parameter int unsigned PE      = 2,
   localparam int unsigned SF       = calc_fold(MatrixW, SIMD),
   localparam int unsigned NF       = calc_fold(MatrixH, PE),
   localparam int unsigned BUF_ADDR = addr_bits(SF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_v,
   output logic                in_rdy,
   input  logic                out_rdy,
   output logic                out_v,
   output logic                write_en,
   output logic                read_en,
   output logic [BUF_ADDR-1:0] addr,
   output logic                sf_last,
   output logic                nf_last
`ifdef MVAU_INP_CTRL_PERF_EN
   ,
   output logic [PERF_W-1:0]   stall_cnt,
   output logic [PERF_W-1:0]   vec_cnt
`endif
);

   localparam int unsigned NF_W = addr_bits(NF);
   localparam logic [BUF_ADDR-1:0] SF_MAX = BUF_ADDR'(SF - 1);
   localparam logic [NF_W-1:0]     NF_MAX = NF_W'(NF - 1);

   mvau_state_e         r_state;
   mvau_state_e         w_state_nxt;
   logic [BUF_ADDR-1:0] r_sf;
   logic [NF_W-1:0]     r_nf;
   logic                w_adv;
   logic                w_sf_wrap;
   logic                w_nf_wrap;

   assign w_sf_wrap = (r_sf == SF_MAX);
   assign w_nf_wrap = (r_nf == NF_MAX);
   // Advance is derived from state and inputs directly so it does not feed back through out_v
   assign w_adv = out_rdy && (((r_state == WRITE) && in_v) || (r_state == READ));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_rdy      = 1'b0;
      out_v       = 1'b0;
      write_en    = 1'b0;
      read_en     = 1'b0;
      case (r_state)
         IDLE: begin
            w_state_nxt = WRITE;
         end
         WRITE: begin
            in_rdy   = out_rdy;
            out_v    = in_v;
            write_en = in_v && out_rdy;
            if (w_adv && w_sf_wrap && (NF > 1)) begin
               w_state_nxt = READ;
            end
         end
         READ: begin
            out_v   = 1'b1;
            read_en = 1'b1;
            if (w_adv && w_sf_wrap && w_nf_wrap) begin
               w_state_nxt = WRITE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sf <= '0;
         r_nf <= '0;
      end else if (w_adv) begin
         if (w_sf_wrap) begin
            r_sf <= '0;
            r_nf <= w_nf_wrap ? '0 : r_nf + NF_W'(1);
         end else begin
            r_sf <= r_sf + BUF_ADDR'(1);
         end
      end
   end

   assign addr    = r_sf;
   assign sf_last = out_v && w_sf_wrap;
   assign nf_last = out_v && w_nf_wrap;

`ifdef MVAU_INP_CTRL_PERF_EN
   logic [PERF_W-1:0] r_stall_cnt;
   logic [PERF_W-1:0] r_vec_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_vec_cnt   <= '0;
      end else begin
         if (out_v && !out_rdy && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
         end
         if (w_adv && w_sf_wrap && w_nf_wrap && (r_vec_cnt != '1)) begin
            r_vec_cnt <= r_vec_cnt + PERF_W'(1);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign vec_cnt   = r_vec_cnt;
`endif

endmodule

// File: tb/tb_mvau_inp_buf_ctrl.sv
// Directed bench for mvau_inp_buf_ctrl: SF=10/NF=10, NF=1 and SF=1 instances share stimulus.
module tb_mvau_inp_buf_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_v;
   logic       out_rdy;

   logic       d1_in_rdy, d1_out_v, d1_we, d1_re, d1_sfl, d1_nfl;
   logic [3:0] d1_addr;
   logic       d2_in_rdy, d2_out_v, d2_we, d2_re, d2_sfl, d2_nfl;
   logic [3:0] d2_addr;
   logic       d3_in_rdy, d3_out_v, d3_we, d3_re, d3_sfl, d3_nfl;
   logic [0:0] d3_addr;
`ifdef MVAU_INP_CTRL_PERF_EN
   logic [31:0] d1_stall, d1_vec, d2_stall, d2_vec, d3_stall, d3_vec;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mvau_inp_buf_ctrl #(.MatrixW(20), .SIMD(2), .MatrixH(20), .PE(2)) u_d1 (
      .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(d1_in_rdy), .out_rdy(out_rdy),
      .out_v(d1_out_v), .write_en(d1_we), .read_en(d1_re), .addr(d1_addr),
      .sf_last(d1_sfl), .nf_last(d1_nfl)
`ifdef MVAU_INP_CTRL_PERF_EN
      , .stall_cnt(d1_stall), .vec_cnt(d1_vec)
`endif
   );

   mvau_inp_buf_ctrl #(.MatrixW(20), .SIMD(2), .MatrixH(2), .PE(2)) u_d2 (
      .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(d2_in_rdy), .out_rdy(out_rdy),
      .out_v(d2_out_v), .write_en(d2_we), .read_en(d2_re), .addr(d2_addr),
      .sf_last(d2_sfl), .nf_last(d2_nfl)
`ifdef MVAU_INP_CTRL_PERF_EN
      , .stall_cnt(d2_stall), .vec_cnt(d2_vec)
`endif
   );

   mvau_inp_buf_ctrl #(.MatrixW(2), .SIMD(2), .MatrixH(6), .PE(2)) u_d3 (
      .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(d3_in_rdy), .out_rdy(out_rdy),
      .out_v(d3_out_v), .write_en(d3_we), .read_en(d3_re), .addr(d3_addr),
      .sf_last(d3_sfl), .nf_last(d3_nfl)
`ifdef MVAU_INP_CTRL_PERF_EN
      , .stall_cnt(d3_stall), .vec_cnt(d3_vec)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_rdy"},  32'(d1_in_rdy), 32'd0);
      chk({tag, "_out_v"},   32'(d1_out_v),  32'd0);
      chk({tag, "_we"},      32'(d1_we),     32'd0);
      chk({tag, "_re"},      32'(d1_re),     32'd0);
      chk({tag, "_addr"},    32'(d1_addr),   32'd0);
      chk({tag, "_sf_last"}, 32'(d1_sfl),    32'd0);
      chk({tag, "_nf_last"}, 32'(d1_nfl),    32'd0);
   endtask

   initial begin
      rst = 1'b1; in_v = 1'b0; out_rdy = 1'b0;
      #1;
      chk_all_zero("rst");

      // Release reset with traffic already offered: IDLE must hold it off one cycle
      @(negedge clk);
      rst = 1'b0; in_v = 1'b1; out_rdy = 1'b1;
      #1;
      chk("idle_out_v",  32'(d1_out_v),  32'd0);
      chk("idle_in_rdy", 32'(d1_in_rdy), 32'd0);
      chk("idle_we",     32'(d1_we),     32'd0);
      @(negedge clk);

      for (int k = 1; k <= 100; k++) begin
         #1;
         chk($sformatf("d1_out_v_%0d", k),  32'(d1_out_v), 32'd1);
         chk($sformatf("d1_we_%0d", k),     32'(d1_we),     32'(k <= 10));
         chk($sformatf("d1_re_%0d", k),     32'(d1_re),     32'(k > 10));
         chk($sformatf("d1_in_rdy_%0d", k), 32'(d1_in_rdy), 32'(k <= 10));
         chk($sformatf("d1_addr_%0d", k),   32'(d1_addr),   32'((k - 1) % 10));
         chk($sformatf("d1_sfl_%0d", k),    32'(d1_sfl),    32'(((k - 1) % 10) == 9));
         chk($sformatf("d1_nfl_%0d", k),    32'(d1_nfl),    32'(k > 90));
         chk($sformatf("d2_we_%0d", k),     32'(d2_we),     32'd1);
         chk($sformatf("d2_re_%0d", k),     32'(d2_re),     32'd0);
         chk($sformatf("d2_addr_%0d", k),   32'(d2_addr),   32'((k - 1) % 10));
         chk($sformatf("d2_nfl_%0d", k),    32'(d2_nfl),    32'd1);
         chk($sformatf("d3_we_%0d", k),     32'(d3_we),     32'((k % 3) == 1));
         chk($sformatf("d3_re_%0d", k),     32'(d3_re),     32'((k % 3) != 1));
         chk($sformatf("d3_addr_%0d", k),   32'(d3_addr),   32'd0);
         chk($sformatf("d3_sfl_%0d", k),    32'(d3_sfl),    32'd1);
         chk($sformatf("d3_nfl_%0d", k),    32'(d3_nfl),    32'((k % 3) == 0));
         @(negedge clk);
      end

      // Second vector: WRITE fold with an in_v gap at sf=6
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("v2_we_%0d", i),   32'(d1_we),   32'd1);
         chk($sformatf("v2_addr_%0d", i), 32'(d1_addr), 32'(i));
         @(negedge clk);
      end
      in_v = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("gap_we",    32'(d1_we),     32'd0);
         chk("gap_out_v", 32'(d1_out_v),  32'd0);
         chk("gap_addr",  32'(d1_addr),   32'd6);
         chk("gap_rdy",   32'(d1_in_rdy), 32'd1);
         @(negedge clk);
      end
      in_v = 1'b1;
      for (int i = 6; i < 10; i++) begin
         #1;
         chk($sformatf("v2_we_%0d", i),   32'(d1_we),   32'd1);
         chk($sformatf("v2_addr_%0d", i), 32'(d1_addr), 32'(i));
         @(negedge clk);
      end

      // READ fold: in_v toggling is ignored
      for (int i = 0; i < 4; i++) begin
         in_v = 1'(i % 2);
         #1;
         chk($sformatf("rd_re_%0d", i),    32'(d1_re),     32'd1);
         chk($sformatf("rd_rdy_%0d", i),   32'(d1_in_rdy), 32'd0);
         chk($sformatf("rd_out_v_%0d", i), 32'(d1_out_v),  32'd1);
         chk($sformatf("rd_addr_%0d", i),  32'(d1_addr),   32'(i));
         @(negedge clk);
      end
      in_v = 1'b1;

      // Back-pressure at READ sf=4
      out_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_addr",  32'(d1_addr),  32'd4);
         chk("bp_out_v", 32'(d1_out_v), 32'd1);
         chk("bp_re",    32'(d1_re),    32'd1);
         @(negedge clk);
      end
      out_rdy = 1'b1;
      #1;
      chk("bp_rel_addr", 32'(d1_addr), 32'd4);
      @(negedge clk);
      #1;
      chk("bp_resume_addr", 32'(d1_addr), 32'd5);
      @(negedge clk);

      // From nf=1 sf=6 to nf=3 sf=7
      repeat (21) @(negedge clk);
      #1;
      chk("pre_rst_addr", 32'(d1_addr), 32'd7);
      chk("pre_rst_re",   32'(d1_re),   32'd1);
      chk("pre_rst_nfl",  32'(d1_nfl),  32'd0);
`ifdef MVAU_INP_CTRL_PERF_EN
      chk("perf_stall", d1_stall, 32'd3);
      chk("perf_vec",   d1_vec,   32'd1);
`endif
      #2;
      rst = 1'b1;
      #1;
      chk_all_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_idle_out_v", 32'(d1_out_v), 32'd0);
      chk("post_idle_we",    32'(d1_we),    32'd0);
`ifdef MVAU_INP_CTRL_PERF_EN
      chk("perf_stall_rst", d1_stall, 32'd0);
      chk("perf_vec_rst",   d1_vec,   32'd0);
`endif
      @(negedge clk);
      #1;
      chk("post_we",   32'(d1_we),   32'd1);
      chk("post_addr", 32'(d1_addr), 32'd0);
      chk("post_re",   32'(d1_re),   32'd0);
      chk("post_nfl",  32'(d1_nfl),  32'd0);
      repeat (10) @(negedge clk);
      #1;
      chk("post_read_re",   32'(d1_re),   32'd1);
      chk("post_read_addr", 32'(d1_addr), 32'd0);
      chk("post_read_nfl",  32'(d1_nfl),  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
